// File: rtl/hack_run_ctrl.sv
// Run/load controller for the Hack CPU: streams a program image into ROM,
// holds the CPU in reset, then gates execution (run / step / halt / breakpoint).
module hack_run_ctrl #(
  parameter int ROM_AW     = 15,
  parameter int CNT_W      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic              cmd_err,
  input  logic [15:0]       ld_data,
  input  logic              ld_valid,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_waddr,
  output logic [15:0]       rom_wdata,
  input  logic [ROM_AW-1:0] pc,
  input  logic              bp_en,
  input  logic [ROM_AW-1:0] bp_addr,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic              halted,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RSTH  = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_STEP  = 3'd5
  } state_t;

  localparam logic [2:0] CMD_LOAD    = 3'b001;
  localparam logic [2:0] CMD_RUN     = 3'b010;
  localparam logic [2:0] CMD_STEP    = 3'b011;
  localparam logic [2:0] CMD_HALT    = 3'b100;
  localparam logic [2:0] CMD_RESTART = 3'b101;

  state_t              state_q, state_d;
  logic [ROM_AW-1:0]   addr_q, addr_d;
  logic [3:0]          rst_cnt_q, rst_cnt_d;
  logic                bp_skip_q, bp_skip_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic                cmd_err_q, cmd_err_d;
  logic                rom_we_q, rom_we_d;
  logic [ROM_AW-1:0]   rom_waddr_q, rom_waddr_d;
  logic [15:0]         rom_wdata_q, rom_wdata_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                cpu_en_q, cpu_en_d;
  logic                ld_ready_q, ld_ready_d;
  logic                halted_q, halted_d;
  logic [2:0]          state_o_q, state_o_d;
  logic                bp_block;
  logic                en_eff;
  logic                cmd_legal;

  // Breakpoint gate: the CPU must not retire the instruction at bp_addr, so the
  // registered enable is masked as soon as pc reaches it (unless just re-armed).
  always_comb begin
    bp_block  = (state_q == S_RUN) && bp_en && (pc == bp_addr) && !bp_skip_q;
    en_eff    = cpu_en_q && !bp_block;
    cmd_legal = cmd_valid && (cmd >= CMD_LOAD) && (cmd <= CMD_RESTART);
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rst_cnt_d   = rst_cnt_q;
    bp_skip_d   = bp_skip_q;
    cycles_d    = cycles_q;
    cmd_err_d   = cmd_valid && !cmd_legal;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;

    if (((state_q == S_RUN) || (state_q == S_STEP)) && en_eff && (cycles_q != {CNT_W{1'b1}})) begin
      cycles_d = cycles_q + CNT_W'(1);
    end else begin
      cycles_d = cycles_q;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_legal) begin
          case (cmd)
            CMD_LOAD: begin
              state_d = S_LOAD;
              addr_d  = {ROM_AW{1'b0}};
            end
            CMD_RESTART: state_d = S_RSTH;
            default:     cmd_err_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (cmd_legal) begin
          cmd_err_d = 1'b1;
        end else begin
          cmd_err_d = cmd_err_d;
        end
        if (ld_valid) begin
          rom_we_d    = 1'b1;
          rom_waddr_d = addr_q;
          rom_wdata_d = ld_data;
          addr_d      = addr_q + ROM_AW'(1);
          if (ld_last) begin
            state_d = S_RSTH;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RSTH: begin
        if (cmd_legal) begin
          cmd_err_d = 1'b1;
        end else begin
          cmd_err_d = cmd_err_d;
        end
        if (rst_cnt_q == 4'(RST_CYCLES - 1)) begin
          state_d = S_PAUSE;
        end else begin
          rst_cnt_d = rst_cnt_q + 4'd1;
        end
      end
      // A step cycle retires on this edge, so commands behave as in PAUSE.
      S_PAUSE, S_STEP: begin
        state_d = S_PAUSE;
        if (cmd_legal) begin
          case (cmd)
            CMD_RUN: begin
              state_d   = S_RUN;
              bp_skip_d = 1'b1;
            end
            CMD_STEP: state_d = S_STEP;
            CMD_LOAD: begin
              state_d = S_LOAD;
              addr_d  = {ROM_AW{1'b0}};
            end
            CMD_RESTART: state_d = S_RSTH;
            default:     state_d = S_PAUSE;
          endcase
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_RUN: begin
        bp_skip_d = 1'b0;
        if (bp_block) begin
          state_d = S_PAUSE;
        end else begin
          state_d = S_RUN;
        end
        if (cmd_legal) begin
          case (cmd)
            CMD_HALT:    state_d = S_PAUSE;
            CMD_RESTART: state_d = S_RSTH;
            CMD_RUN:     cmd_err_d = 1'b0;
            default:     cmd_err_d = 1'b1;
          endcase
        end else begin
          cmd_err_d = cmd_err_d;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_RSTH) && (state_q != S_RSTH)) begin
      rst_cnt_d = 4'd0;
      cycles_d  = {CNT_W{1'b0}};
    end else begin
      rst_cnt_d = rst_cnt_d;
    end

    cpu_reset_d = (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_RSTH);
    cpu_en_d    = (state_d == S_RSTH) || (state_d == S_RUN) || (state_d == S_STEP);
    ld_ready_d  = (state_d == S_LOAD);
    halted_d    = (state_d == S_IDLE) || (state_d == S_PAUSE) || (state_d == S_STEP);
    if (state_d == S_STEP) begin
      state_o_d = 3'd4;
    end else begin
      state_o_d = state_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= {ROM_AW{1'b0}};
      rst_cnt_q   <= 4'd0;
      bp_skip_q   <= 1'b0;
      cycles_q    <= {CNT_W{1'b0}};
      cmd_err_q   <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= {ROM_AW{1'b0}};
      rom_wdata_q <= 16'h0000;
      cpu_reset_q <= 1'b1;
      cpu_en_q    <= 1'b0;
      ld_ready_q  <= 1'b0;
      halted_q    <= 1'b1;
      state_o_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rst_cnt_q   <= rst_cnt_d;
      bp_skip_q   <= bp_skip_d;
      cycles_q    <= cycles_d;
      cmd_err_q   <= cmd_err_d;
      rom_we_q    <= rom_we_d;
      rom_waddr_q <= rom_waddr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_en_q    <= cpu_en_d;
      ld_ready_q  <= ld_ready_d;
      halted_q    <= halted_d;
      state_o_q   <= state_o_d;
    end
  end

  assign cmd_err   = cmd_err_q;
  assign ld_ready  = ld_ready_q;
  assign rom_we    = rom_we_q;
  assign rom_waddr = rom_waddr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign cpu_en    = en_eff;
  assign halted    = halted_q;
  assign state     = state_o_q;
  assign cycles    = cycles_q;

endmodule
